// File: rtl/ddr_tx_if.sv
// Transmit-side signal bundle of the HDR-DDR transmitter: SCL strobes, controller field select,
// register-file data, external CRC engine hookup and the serial/handshake outputs.
interface ddr_tx_if;
   logic       i_sclgen_scl_pos_edge;
   logic       i_sclgen_scl_neg_edge;
   logic       i_ddrccc_tx_en;
   logic [3:0] i_ddrccc_tx_mode;
   logic [7:0] i_regf_tx_data;
   logic [4:0] i_crc_value;
   logic       i_crc_valid;
   logic       o_sdahnd_tx_sda;
   logic       o_ddrccc_tx_mode_done;
   logic       o_crc_en;

   modport master (
      output i_sclgen_scl_pos_edge,
      output i_sclgen_scl_neg_edge,
      output i_ddrccc_tx_en,
      output i_ddrccc_tx_mode,
      output i_regf_tx_data,
      output i_crc_value,
      output i_crc_valid,
      input  o_sdahnd_tx_sda,
      input  o_ddrccc_tx_mode_done,
      input  o_crc_en
   );

   modport slave (
      input  i_sclgen_scl_pos_edge,
      input  i_sclgen_scl_neg_edge,
      input  i_ddrccc_tx_en,
      input  i_ddrccc_tx_mode,
      input  i_regf_tx_data,
      input  i_crc_value,
      input  i_crc_valid,
      output o_sdahnd_tx_sda,
      output o_ddrccc_tx_mode_done,
      output o_crc_en
   );
endinterface

// File: rtl/ddr_tx.sv
// HDR-DDR transmitter: serialises preamble, data, token, parity and CRC5 bits MSB first, one per SCL edge.
// Define DDR_TX_INTERNAL_CRC_EN to build the CRC5 with an internal LFSR instead of the external engine.
module ddr_tx #(
   parameter logic [4:0] CRC_INIT  = 5'h1F,
   parameter logic [3:0] TOKEN_VAL = 4'hC
) (
   input logic     i_sys_clk,
   input logic     i_sys_rst,
   ddr_tx_if.slave bus
);
   localparam logic [3:0] MODE_PRE_ZERO = 4'b0000;
   localparam logic [3:0] MODE_PRE_ONE  = 4'b0001;
   localparam logic [3:0] MODE_BYTE     = 4'b0011;
   localparam logic [3:0] MODE_TOKEN    = 4'b0101;
   localparam logic [3:0] MODE_PARITY   = 4'b0110;
   localparam logic [3:0] MODE_CRC      = 4'b0111;

   typedef enum logic {ST_LOAD = 1'b0, ST_SHIFT = 1'b1} state_t;

   state_t      state;
   logic [3:0]  cur_mode;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        byte_idx;
   logic [15:0] word;
   logic        sda_q;
   logic        done_q;
   logic        crc_en_q;

   logic        scl_edge;
   logic        mode_valid;
   logic        tx_active;
   logic        abort;
   logic [3:0]  field_width;
   logic [7:0]  payload;
   logic        load_ok;
   logic [4:0]  crc_payload;
   logic        crc_ready;
   logic        parity_p1;
   logic        parity_p0;
   logic        tx_fire;
   logic        tx_bit;
   logic        field_done;
   logic [3:0]  done_mode;

`ifdef DDR_TX_INTERNAL_CRC_EN
   logic [4:0]  lfsr;
   assign crc_payload = lfsr;
   assign crc_ready   = 1'b1;
`else
   assign crc_payload = bus.i_crc_value;
   assign crc_ready   = bus.i_crc_valid;
`endif

   assign scl_edge  = bus.i_sclgen_scl_pos_edge | bus.i_sclgen_scl_neg_edge;
   assign tx_active = bus.i_ddrccc_tx_en & mode_valid;
   assign abort     = (state == ST_SHIFT) && (bus.i_ddrccc_tx_mode != cur_mode);
   assign parity_p1 = ^(word & 16'hAAAA);
   assign parity_p0 = ~^(word & 16'h5555);
   assign load_ok   = (bus.i_ddrccc_tx_mode != MODE_CRC) || crc_ready;

   always_comb begin
      field_width = 4'd0;
      payload     = 8'h00;
      mode_valid  = 1'b1;
      case (bus.i_ddrccc_tx_mode)
         MODE_PRE_ZERO: begin field_width = 4'd1; payload = 8'h00; end
         MODE_PRE_ONE:  begin field_width = 4'd1; payload = 8'h01; end
         MODE_BYTE:     begin field_width = 4'd8; payload = bus.i_regf_tx_data; end
         MODE_TOKEN:    begin field_width = 4'd4; payload = {4'h0, TOKEN_VAL}; end
         MODE_PARITY:   begin field_width = 4'd2; payload = {6'b0, parity_p1, parity_p0}; end
         MODE_CRC:      begin field_width = 4'd5; payload = {3'b0, crc_payload}; end
         default:       mode_valid = 1'b0;
      endcase
   end

   // A field fires on an SCL edge; LOAD drives the payload MSB, SHIFT walks down the held copy.
   always_comb begin
      tx_fire    = 1'b0;
      tx_bit     = sda_q;
      field_done = 1'b0;
      done_mode  = cur_mode;
      if (tx_active && !abort && scl_edge) begin
         if (state == ST_LOAD) begin
            tx_fire    = load_ok;
            tx_bit     = payload[3'(field_width - 4'd1)];
            field_done = load_ok && (field_width == 4'd1);
            done_mode  = bus.i_ddrccc_tx_mode;
         end else begin
            tx_fire    = 1'b1;
            tx_bit     = shreg[bit_cnt];
            field_done = (bit_cnt == 3'd0);
         end
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         state    <= ST_LOAD;
         cur_mode <= MODE_PRE_ZERO;
         bit_cnt  <= 3'd0;
         shreg    <= 8'h00;
         byte_idx <= 1'b0;
         word     <= 16'h0000;
         sda_q    <= 1'b1;
         done_q   <= 1'b0;
         crc_en_q <= 1'b0;
      end else begin
         done_q <= field_done;
`ifdef DDR_TX_INTERNAL_CRC_EN
         crc_en_q <= 1'b0;
`else
         crc_en_q <= bus.i_ddrccc_tx_en && (bus.i_ddrccc_tx_mode == MODE_CRC);
`endif
         if (!tx_active) begin
            sda_q   <= 1'b1;
            state   <= ST_LOAD;
            bit_cnt <= 3'd0;
         end else if (abort) begin
            state <= ST_LOAD;
         end else if (tx_fire) begin
            sda_q <= tx_bit;
            if (state == ST_LOAD) begin
               shreg    <= payload;
               cur_mode <= bus.i_ddrccc_tx_mode;
               if (!field_done) begin
                  bit_cnt <= 3'(field_width - 4'd2);
                  state   <= ST_SHIFT;
               end
            end else if (field_done) begin
               state <= ST_LOAD;
            end else begin
               bit_cnt <= bit_cnt - 3'd1;
            end
         end

         // Completed bytes build the parity word; preambles start a fresh word.
         if (!bus.i_ddrccc_tx_en) begin
            byte_idx <= 1'b0;
         end else if (field_done) begin
            case (done_mode)
               MODE_BYTE: begin
                  if (byte_idx) word[7:0]  <= shreg;
                  else          word[15:8] <= shreg;
                  byte_idx <= ~byte_idx;
               end
               MODE_PARITY: byte_idx <= 1'b0;
               MODE_PRE_ZERO, MODE_PRE_ONE: begin
                  byte_idx <= 1'b0;
                  word     <= 16'h0000;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef DDR_TX_INTERNAL_CRC_EN
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         lfsr <= CRC_INIT;
      end else if (field_done && (done_mode inside {MODE_PRE_ZERO, MODE_PRE_ONE, MODE_CRC})) begin
         lfsr <= CRC_INIT;
      end else if (tx_fire && (done_mode == MODE_BYTE)) begin
         lfsr <= {lfsr[3:0], 1'b0} ^ ((lfsr[4] ^ tx_bit) ? 5'h05 : 5'h00);
      end
   end
`endif

   assign bus.o_sdahnd_tx_sda       = sda_q;
   assign bus.o_ddrccc_tx_mode_done = done_q;
   assign bus.o_crc_en              = crc_en_q;
endmodule

// File: tb/tb_ddr_tx.sv
// Self-checking bench for ddr_tx: a field-level reference model sets per-clock expectations.
// Build with +define+DDR_TX_INTERNAL_CRC_EN to exercise the internal CRC5 variant.
`timescale 1ns/1ps
module tb_ddr_tx;
   localparam logic [3:0] M_PRE0   = 4'b0000;
   localparam logic [3:0] M_PRE1   = 4'b0001;
   localparam logic [3:0] M_BYTE   = 4'b0011;
   localparam logic [3:0] M_TOKEN  = 4'b0101;
   localparam logic [3:0] M_PARITY = 4'b0110;
   localparam logic [3:0] M_CRC    = 4'b0111;
   localparam logic [3:0] M_IDLE   = 4'b1111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ddr_tx_if bus();

   ddr_tx #(.CRC_INIT(5'h1F), .TOKEN_VAL(4'hC)) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst_n),
      .bus       (bus)
   );

   int   passCount = 0;
   int   checkCount = 0;
   logic expNextSda = 1'b1;
   logic expNextDone = 1'b0;
   logic expNextCrcEn = 1'b0;
   bit   chkNext = 1'b0;
   bit   edgeNext = 1'b0;
   bit   usePos = 1'b1;
   logic [7:0] seenBits = 8'h00;

   logic        mSda;
   logic [15:0] mWord;
   logic        mIdx;
   logic [4:0]  mLfsr;
   logic [4:0]  mCrcExt;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Expectations set at a negedge apply to the outputs after the following posedge.
   always @(posedge clk) begin
      logic eSda, eDone, eCrc;
      bit   doChk, isEdge;
      eSda = expNextSda; eDone = expNextDone; eCrc = expNextCrcEn;
      doChk = chkNext; isEdge = edgeNext;
      #1;
      if (doChk) begin
         checkOutput("sda",    {7'b0, bus.o_sdahnd_tx_sda},       {7'b0, eSda});
         checkOutput("done",   {7'b0, bus.o_ddrccc_tx_mode_done}, {7'b0, eDone});
         checkOutput("crc_en", {7'b0, bus.o_crc_en},              {7'b0, eCrc});
      end
      if (isEdge) seenBits = {seenBits[6:0], bus.o_sdahnd_tx_sda};
   end

   task automatic applyStimulus(input logic pos, input logic neg, input logic eSda, input logic eDone, input bit doChk);
      bus.i_sclgen_scl_pos_edge = pos;
      bus.i_sclgen_scl_neg_edge = neg;
      expNextSda  = eSda;
      expNextDone = eDone;
`ifdef DDR_TX_INTERNAL_CRC_EN
      expNextCrcEn = 1'b0;
`else
      expNextCrcEn = rst_n && bus.i_ddrccc_tx_en && (bus.i_ddrccc_tx_mode == M_CRC);
`endif
      chkNext  = doChk;
      edgeNext = pos | neg;
      @(negedge clk);
   endtask

   task automatic edgeStim(input logic eSda, input logic eDone);
      applyStimulus(usePos, !usePos, eSda, eDone, 1'b1);
      usePos = !usePos;
   endtask

   task automatic gapStim();
      applyStimulus(1'b0, 1'b0, mSda, 1'b0, 1'b1);
   endtask

   function automatic logic [4:0] lfsrStep(input logic [4:0] c, input logic b);
      logic fb;
      fb = c[4] ^ b;
      return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
   endfunction

   task automatic modelReset();
      mSda = 1'b1; mWord = 16'h0000; mIdx = 1'b0; mLfsr = 5'h1F;
   endtask

   task automatic fieldPayload(input logic [3:0] mode, input logic [7:0] data, output int w, output logic [7:0] pay);
      int o, e;
      o = 0; e = 0;
      for (int i = 0; i < 16; i++) if (mWord[i]) begin
         if (i % 2 == 1) o++;
         else e++;
      end
      w = 0; pay = 8'h00;
      case (mode)
         M_PRE0:   begin w = 1; pay = 8'h00; end
         M_PRE1:   begin w = 1; pay = 8'h01; end
         M_BYTE:   begin w = 8; pay = data; end
         M_TOKEN:  begin w = 4; pay = 8'h0C; end
         M_PARITY: begin w = 2; pay = {6'b0, logic'(o % 2 == 1), logic'(e % 2 == 0)}; end
`ifdef DDR_TX_INTERNAL_CRC_EN
         M_CRC:    begin w = 5; pay = {3'b0, mLfsr}; end
`else
         M_CRC:    begin w = 5; pay = {3'b0, mCrcExt}; end
`endif
         default:  ;
      endcase
   endtask

   task automatic completeField(input logic [3:0] mode, input logic [7:0] pay);
      case (mode)
         M_BYTE: begin
            if (mIdx) mWord[7:0] = pay;
            else      mWord[15:8] = pay;
            mIdx = !mIdx;
         end
         M_PARITY: mIdx = 1'b0;
         M_PRE0, M_PRE1: begin mIdx = 1'b0; mWord = 16'h0000; mLfsr = 5'h1F; end
         M_CRC: mLfsr = 5'h1F;
         default: ;
      endcase
   endtask

   // Presents a mode for one quiet clock, then drives nEdges edges; fewer than the width leaves it mid-field.
   task automatic sendField(input logic [3:0] mode, input logic [7:0] data, input int nEdges);
      int w;
      logic [7:0] pay;
      logic b;
      bus.i_ddrccc_tx_mode = mode;
      bus.i_regf_tx_data   = data;
      gapStim();
      fieldPayload(mode, data, w, pay);
      seenBits = 8'h00;
      for (int k = 0; k < nEdges; k++) begin
         b = pay[w - 1 - k];
         if (mode == M_BYTE) mLfsr = lfsrStep(mLfsr, b);
         mSda = b;
         edgeStim(b, k == w - 1);
         gapStim();
      end
      if (nEdges == w) completeField(mode, pay);
   endtask

   initial begin
      bus.i_sclgen_scl_pos_edge = 1'b0;
      bus.i_sclgen_scl_neg_edge = 1'b0;
      bus.i_ddrccc_tx_en        = 1'b1;
      bus.i_ddrccc_tx_mode      = M_CRC;
      bus.i_regf_tx_data        = 8'h00;
      bus.i_crc_value           = 5'h00;
      bus.i_crc_valid           = 1'b0;
      modelReset();
      mCrcExt = 5'h00;
      @(negedge clk);

      // Reset wins over an active CRC request and stray edges.
      rst_n = 1'b0;
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b1;
      bus.i_ddrccc_tx_mode = M_IDLE;
      gapStim();

      sendField(M_PRE1, 8'h00, 1);
      checkOutput("pre_one_bit", {7'b0, seenBits[0]}, 8'h01);
      sendField(M_PRE0, 8'h00, 1);
      checkOutput("pre_zero_bit", {7'b0, seenBits[0]}, 8'h00);

      sendField(M_BYTE, 8'hA5, 8);
      checkOutput("byte_a5", seenBits, 8'hA5);
      sendField(M_BYTE, 8'h3C, 8);
      sendField(M_PARITY, 8'h00, 2);
      checkOutput("parity_a53c", {6'b0, seenBits[1:0]}, 8'h01);
      sendField(M_TOKEN, 8'h00, 4);
      checkOutput("token", {4'b0, seenBits[3:0]}, 8'h0C);

      bus.i_ddrccc_tx_mode = M_IDLE;
      mSda = 1'b1;
      gapStim();
      edgeStim(1'b1, 1'b0);
      gapStim();

      // CRC waits for a valid value (external engine); internal CRC ignores valid entirely.
      sendField(M_PRE0, 8'h00, 1);
      bus.i_ddrccc_tx_mode = M_CRC;
      bus.i_crc_valid = 1'b0;
      bus.i_crc_value = 5'h09;
      gapStim();
`ifndef DDR_TX_INTERNAL_CRC_EN
      repeat (3) begin
         edgeStim(mSda, 1'b0);
         gapStim();
      end
      bus.i_crc_valid = 1'b1;
      bus.i_crc_value = 5'h16;
      mCrcExt = 5'h16;
      sendField(M_CRC, 8'h00, 5);
      checkOutput("crc_ext_16", {3'b0, seenBits[4:0]}, 8'h16);
`else
      sendField(M_CRC, 8'h00, 5);
      checkOutput("crc_int_init", {3'b0, seenBits[4:0]}, 8'h1F);
`endif
      bus.i_crc_valid = 1'b0;

      // Reset after three bits of a byte, then the byte restarts from its MSB.
      sendField(M_BYTE, 8'h96, 3);
      rst_n = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b1;
      sendField(M_BYTE, 8'h96, 8);
      checkOutput("byte_after_reset", seenBits, 8'h96);

      // Mode change mid-byte aborts silently; the token then goes out whole.
      sendField(M_BYTE, 8'h5A, 4);
      sendField(M_TOKEN, 8'h00, 4);
      checkOutput("token_after_abort", {4'b0, seenBits[3:0]}, 8'h0C);

      // Disabling clears byte_idx, so the second byte lands in the upper half of the parity word.
      sendField(M_PRE1, 8'h00, 1);
      sendField(M_BYTE, 8'h80, 8);
      bus.i_ddrccc_tx_en = 1'b0;
      mIdx = 1'b0;
      mSda = 1'b1;
      gapStim();
      bus.i_ddrccc_tx_en = 1'b1;
      sendField(M_BYTE, 8'h02, 8);
      sendField(M_PARITY, 8'h00, 2);
      checkOutput("parity_after_disable", {6'b0, seenBits[1:0]}, 8'h03);

      // Two zero bytes followed by a CRC field.
      sendField(M_PRE0, 8'h00, 1);
      sendField(M_BYTE, 8'h00, 8);
      sendField(M_BYTE, 8'h00, 8);
      bus.i_crc_valid = 1'b1;
      bus.i_crc_value = 5'h0B;
      mCrcExt = 5'h0B;
`ifdef DDR_TX_INTERNAL_CRC_EN
      begin
         logic [4:0] expCrc;
         expCrc = mLfsr;
         sendField(M_CRC, 8'h00, 5);
         checkOutput("crc_int_zero_bytes", {3'b0, seenBits[4:0]}, {3'b0, expCrc});
      end
`else
      sendField(M_CRC, 8'h00, 5);
      checkOutput("crc_ext_0b", {3'b0, seenBits[4:0]}, 8'h0B);
`endif
      bus.i_ddrccc_tx_mode = M_IDLE;
      mSda = 1'b1;
      gapStim();
      chkNext = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
